imgproc_frame_ctrl: RTL and testbench
=====================================

// Module: imgproc_frame_ctrl
// PURPOSE
//  Frame sequencer placed between the sensor pixel stream and imgproc.
//  - Accepts raw pixels qualified by iDVAL and generates the raster coordinates (oX_Cont/oY_Cont).
//  - Gates capture with start/stop control and latches the processing mode (iSW) only at frame start.
//  - Flags frame boundaries and line-buffer priming so imgproc and downstream logic see whole, consistent frames.
// PARAMETERS
//  WIDTH        1280  active pixels per line
//  HEIGHT       960   active lines per frame
//  CW           16    coordinate / frame-counter width
//  PRIME_LINES  1     lines imgproc must buffer before its output is meaningful
// PORTS
//  iCLK         in   1   single clock; all logic on rising edge
//  iRST         in   1   asynchronous, active-low reset
//  iSTART       in   1   capture request; level or pulse, sampled each cycle
//  iSTOP        in   1   stop request; honoured at end of current frame
//  iDATA        in   12  raw sensor pixel
//  iDVAL        in   1   iDATA valid this cycle
//  iSW          in   1   requested processing mode
//  oDATA        out  12  iDATA delayed one cycle, aligned to coordinates
//  oDVAL        out  1   pixel valid to imgproc (accepted pixel, one cycle late)
//  oX_Cont      out  CW  column of the pixel on oDATA, 0..WIDTH-1
//  oY_Cont      out  CW  row of the pixel on oDATA, 0..HEIGHT-1
//  oMODE        out  1   mode in force for the current frame
//  oSOF         out  1   high with pixel (0,0)
//  oEOF         out  1   high with pixel (WIDTH-1,HEIGHT-1)
//  oPRIMED      out  1   high with every pixel whose row >= PRIME_LINES
//  oBUSY        out  1   state != IDLE
//  oFRAME_CNT   out  CW  completed frames since reset, wraps at 2^CW
// BEHAVIOUR
//  Reset (iRST=0, async):
//  - State returns to IDLE.
//  - Internal x/y counters and every output are cleared to 0.
//  - The stop_pend flag is cleared.
//  States:
//  - IDLE: iSTART=1 -> RUN. Counters are held at 0 and oDVAL stays 0. iSTOP is ignored.
//  - RUN: every cycle with iDVAL=1 accepts one pixel.
//    - iSTART is ignored.
//    - iSTOP=1 sets stop_pend.
//    - The EOF pixel with stop_pend set (or iSTOP=1 in that same cycle) -> IDLE and clears stop_pend.
//  - A pixel is accepted iff state==RUN and iDVAL=1. iDVAL while IDLE is dropped.
//  Latency: exactly 1 cycle. For a pixel accepted in cycle N, the following are all registered and valid in cycle N+1:
//    oDVAL=1, oDATA, oX_Cont, oY_Cont, oSOF, oEOF, oPRIMED.
//  - With no accepted pixel, oDVAL=0, oSOF=0, oEOF=0 and oPRIMED=0. oDATA, oX_Cont and oY_Cont hold their last values.
//  Counters advance only on accepted pixels:
//  - x increments on each accepted pixel; x==WIDTH-1 wraps to 0 and increments y.
//  - x==WIDTH-1 with y==HEIGHT-1 wraps both to 0 (EOF).
//  - Gaps in iDVAL (blanking) freeze the counters.
//  Mode: oMODE loads iSW from the cycle the (0,0) pixel is accepted, so it updates together with oSOF.
//  - oMODE then holds for the whole frame.
//  - iSW changes mid-frame have no effect.
//  Frame count: oFRAME_CNT increments in the same cycle oEOF=1, and wraps modulo 2^CW.
//  Stop then restart: on entry to IDLE the counters are already 0, so the next RUN starts at (0,0) with oSOF.
//  iSTART and iSTOP together in IDLE: enter RUN, stop ignored.
//  oBUSY is high in RUN, including while waiting for the EOF pixel to complete a stop.
// TESTING (bench params WIDTH=4, HEIGHT=3, PRIME_LINES=1)
//  1. Reset asserted mid-frame -> all outputs 0 immediately; after release, iDVAL pulses without iSTART -> oDVAL stays 0.
//  2. iSTART then 12 continuous iDVAL, iDATA=k:
//     - oDVAL follows 1 cycle late with (x,y)=(0,0)..(3,2) and oDATA=k.
//     - oSOF is on pixel 0 and oEOF on pixel 11.
//     - oPRIMED=1 from pixel 4.
//     - oFRAME_CNT=1.
//  3. iDVAL toggled 1/0 each cycle -> coordinates advance only on valid cycles, with no skipped or repeated (x,y).
//  4. iSW=1 at SOF, iSW=0 at pixel 5 -> oMODE=1 for all of frame 0; iSW=0 at next SOF -> oMODE=0 for frame 1.
//  5. iSTOP pulsed at pixel 3 -> frame completes to oEOF, then oBUSY=0. Later iDVAL is ignored. iSTART restarts at (0,0).
//  6. iSTOP in the same cycle as the EOF pixel -> IDLE after that frame. Running 2^CW frames wraps oFRAME_CNT to 0.

Source files
------------

// File: rtl/imgproc_frame_ctrl.sv
// Frame sequencer between the sensor pixel stream and imgproc: raster coordinates,
// start/stop gating, per-frame mode latch, frame/prime flags and a frame counter.
module imgproc_frame_ctrl #(
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned HEIGHT      = 960,
  parameter int unsigned CW          = 16,
  parameter int unsigned PRIME_LINES = 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iSTOP,
  input  logic [11:0]   iDATA,
  input  logic          iDVAL,
  input  logic          iSW,
  output logic [11:0]   oDATA,
  output logic          oDVAL,
  output logic [CW-1:0] oX_Cont,
  output logic [CW-1:0] oY_Cont,
  output logic          oMODE,
  output logic          oSOF,
  output logic          oEOF,
  output logic          oPRIMED,
  output logic          oBUSY,
  output logic [CW-1:0] oFRAME_CNT
);

  localparam int unsigned DW = 12;
  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] Y_PRIME = CW'(PRIME_LINES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          stop_pend_q;

  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          eof_pix;
  logic          sof_pix;
  logic          stop_req;

  // Pixel qualification and next-state decode
  always_comb begin
    state_d  = state_q;
    accept   = (state_q == RUN) && iDVAL;
    last_col = (x_q == X_LAST);
    last_row = (y_q == Y_LAST);
    eof_pix  = last_col && last_row;
    sof_pix  = (x_q == '0) && (y_q == '0);
    stop_req = stop_pend_q || iSTOP;
    case (state_q)
      IDLE: begin
        if (iSTART) state_d = RUN;
      end
      RUN: begin
        if (accept && eof_pix && stop_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A stop request waits for the EOF pixel; it is dropped once the frame closes
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stop_pend_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (state_d == IDLE)  stop_pend_q <= 1'b0;
      else if (iSTOP)       stop_pend_q <= 1'b1;
    end else begin
      stop_pend_q <= 1'b0;
    end
  end

  // Raster position of the next accepted pixel; blanking freezes it
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        x_q <= '0;
        y_q <= last_row ? '0 : y_q + CW'(1);
      end else begin
        x_q <= x_q + CW'(1);
      end
    end
  end

  // Per-pixel outputs, one cycle behind acceptance
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
      oSOF    <= 1'b0;
      oEOF    <= 1'b0;
      oPRIMED <= 1'b0;
    end else if (accept) begin
      oDATA   <= iDATA[DW-1:0];
      oDVAL   <= 1'b1;
      oX_Cont <= x_q;
      oY_Cont <= y_q;
      oSOF    <= sof_pix;
      oEOF    <= eof_pix;
      oPRIMED <= (y_q >= Y_PRIME);
    end else begin
      oDVAL   <= 1'b0;
      oSOF    <= 1'b0;
      oEOF    <= 1'b0;
      oPRIMED <= 1'b0;
    end
  end

  // Frame-level status: mode sampled at SOF, completed-frame count, busy
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oMODE      <= 1'b0;
      oFRAME_CNT <= '0;
      oBUSY      <= 1'b0;
    end else begin
      oBUSY <= (state_d == RUN);
      if (accept && sof_pix) oMODE <= iSW;
      if (accept && eof_pix) oFRAME_CNT <= oFRAME_CNT + CW'(1);
    end
  end

endmodule

// File: tb/tb_imgproc_frame_ctrl.sv
// Randomised self-checking bench for imgproc_frame_ctrl against a pixel-index reference model.
module tb_imgproc_frame_ctrl;

  localparam int TW  = 4;
  localparam int TH  = 3;
  localparam int TCW = 4;
  localparam int TP  = 1;
  localparam int NPIX = TW * TH;
  localparam int VW = 18 + 3 * TCW;

  logic           iCLK = 1'b0;
  logic           iRST;
  logic           iSTART, iSTOP, iDVAL, iSW;
  logic [11:0]    iDATA;
  logic [11:0]    oDATA;
  logic           oDVAL, oMODE, oSOF, oEOF, oPRIMED, oBUSY;
  logic [TCW-1:0] oX_Cont, oY_Cont, oFRAME_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  imgproc_frame_ctrl #(.WIDTH(TW), .HEIGHT(TH), .CW(TCW), .PRIME_LINES(TP)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iDATA(iDATA),
    .iDVAL(iDVAL), .iSW(iSW), .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont), .oMODE(oMODE), .oSOF(oSOF), .oEOF(oEOF), .oPRIMED(oPRIMED),
    .oBUSY(oBUSY), .oFRAME_CNT(oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  logic [VW-1:0] act_vec;
  logic [VW-1:0] exp_vec;
  assign act_vec = {oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF, oPRIMED, oMODE, oBUSY, oFRAME_CNT};

  // Reference model: running flag, pending stop, index of next pixel in frame
  bit          m_run, m_pend, m_mode;
  int          m_pix, m_frames;
  logic        e_dval, e_sof, e_eof, e_primed;
  logic [11:0] e_data;
  int          e_x, e_y;

  function automatic void model_reset();
    m_run = 0; m_pend = 0; m_mode = 0; m_pix = 0; m_frames = 0;
    e_dval = 0; e_sof = 0; e_eof = 0; e_primed = 0; e_data = '0; e_x = 0; e_y = 0;
    exp_vec = '0;
  endfunction

  function automatic void model_update();
    bit last;
    e_dval = 0; e_sof = 0; e_eof = 0; e_primed = 0;
    if (!m_run) begin
      if (iSTART) m_run = 1;
    end else begin
      last = 0;
      if (iDVAL) begin
        e_dval   = 1;
        e_data   = iDATA;
        e_x      = m_pix % TW;
        e_y      = m_pix / TW;
        e_sof    = (m_pix == 0);
        e_eof    = (m_pix == NPIX - 1);
        e_primed = (m_pix >= TW * TP);
        if (m_pix == 0) m_mode = iSW;
        if (e_eof) begin
          last = 1;
          m_pix = 0;
          m_frames = (m_frames + 1) % (1 << TCW);
        end else begin
          m_pix++;
        end
      end
      if (last && (m_pend || iSTOP)) begin
        m_run = 0;
        m_pend = 0;
      end else if (iSTOP) begin
        m_pend = 1;
      end
    end
    exp_vec = {e_dval, e_data, TCW'(e_x), TCW'(e_y), e_sof, e_eof, e_primed, m_mode, m_run, TCW'(m_frames)};
  endfunction

  task automatic step(input logic st, input logic sp, input logic dv, input logic sw, input logic [11:0] d);
    iSTART = st; iSTOP = sp; iDVAL = dv; iSW = sw; iDATA = d;
    model_update();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 0; iSTART = 0; iSTOP = 0; iDVAL = 0; iSW = 0; iDATA = '0;
    model_reset();
    repeat (2) @(posedge iCLK);
    #1;
    n_checks++;
    if (act_vec !== '0) begin
      n_fail++; $display("FAIL reset_init: got %h expected 0", act_vec);
    end
    iRST = 1;
    step(1, 0, 0, 0, 12'h000);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 1, 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset_preframe: got %h expected %h", act_vec, exp_vec);
      end
    end
    #2 iRST = 0;
    #1;
    n_checks++;
    if (act_vec !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", act_vec);
    end
    model_reset();
    @(posedge iCLK);
    #1 iRST = 1;
    for (int k = 0; k < 4; k++) begin
      step(0, k[0], 1, 1, 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec || oDVAL !== 1'b0) begin
        n_fail++; $display("FAIL idle_drop: got %h expected %h", act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_frame();
    step(1, 0, 0, 0, 12'h000);
    for (int k = 0; k < NPIX; k++) begin
      step(1'($urandom), 0, 1, 0, 12'(k));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL frame_pix%0d: got %h expected %h", k, act_vec, exp_vec);
      end
      n_checks++;
      if (oSOF !== (k == 0) || oEOF !== (k == NPIX - 1) || oPRIMED !== (k >= 4) || oDATA !== 12'(k)) begin
        n_fail++; $display("FAIL frame_flags%0d: sof=%b eof=%b primed=%b data=%0d", k, oSOF, oEOF, oPRIMED, oDATA);
      end
    end
    n_checks++;
    if (oFRAME_CNT !== TCW'(1) || oBUSY !== 1'b1) begin
      n_fail++; $display("FAIL frame_cnt: got %0d busy=%b expected 1 busy=1", oFRAME_CNT, oBUSY);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 2 * NPIX; i++) begin
      step(1'($urandom), 0, (i % 2 == 0), 1'($urandom), 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL gaps_cyc%0d: got %h expected %h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_mode();
    logic sw;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < NPIX; p++) begin
        for (int g = 0; g < int'($urandom_range(0, 1)); g++) step(0, 0, 0, 1'($urandom), 12'($urandom));
        if (p == 0)      sw = (f == 0);
        else if (p >= 5) sw = (f != 0);
        else             sw = 1'($urandom);
        step(0, 0, 1, sw, 12'($urandom));
        n_checks++;
        if (act_vec !== exp_vec || oMODE !== (f == 0)) begin
          n_fail++; $display("FAIL mode_f%0d_p%0d: got %h mode=%b expected %h", f, p, act_vec, oMODE, exp_vec);
        end
      end
    end
  endtask

  task automatic test_stop();
    for (int p = 0; p < NPIX; p++) begin
      if (p % 3 == 1) step(0, 0, 0, 0, 12'($urandom));
      step(0, (p == 3), 1, 0, 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL stop_p%0d: got %h expected %h", p, act_vec, exp_vec);
      end
    end
    n_checks++;
    if (oBUSY !== 1'b0 || oEOF !== 1'b1) begin
      n_fail++; $display("FAIL stop_idle: busy=%b eof=%b expected busy=0 eof=1", oBUSY, oEOF);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec || oDVAL !== 1'b0) begin
        n_fail++; $display("FAIL stop_drop%0d: got %h expected %h", k, act_vec, exp_vec);
      end
    end
    step(1, 0, 0, 0, 12'h000);
    for (int p = 0; p < NPIX; p++) begin
      step(0, 0, 1, 0, 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL restart_p%0d: got %h expected %h", p, act_vec, exp_vec);
      end
      if (p == 0) begin
        n_checks++;
        if (oSOF !== 1'b1 || oX_Cont !== '0 || oY_Cont !== '0) begin
          n_fail++; $display("FAIL restart_sof: sof=%b x=%0d y=%0d expected 1,0,0", oSOF, oX_Cont, oY_Cont);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit last;
    for (int p = 0; p < NPIX; p++) begin
      step(0, (p == NPIX - 1), 1, 0, 12'($urandom));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL eofstop_p%0d: got %h expected %h", p, act_vec, exp_vec);
      end
    end
    n_checks++;
    if (oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL eofstop_idle: busy=%b expected 0", oBUSY);
    end
    step(1, 1, 0, 0, 12'h000);
    last = 0;
    for (int f = 0; f < 20 && !last; f++) begin
      last = (m_frames == (1 << TCW) - 1);
      for (int p = 0; p < NPIX; p++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'($urandom), 0, 0, 1'($urandom), 12'($urandom));
        step(1'($urandom), (last && p == NPIX - 1), 1, 1'($urandom), 12'($urandom));
        n_checks++;
        if (act_vec !== exp_vec) begin
          n_fail++; $display("FAIL wrap_f%0d_p%0d: got %h expected %h", f, p, act_vec, exp_vec);
        end
      end
      if (!last) begin
        n_checks++;
        if (oBUSY !== 1'b1) begin
          n_fail++; $display("FAIL wrap_busy%0d: busy=%b expected 1", f, oBUSY);
        end
      end
    end
    n_checks++;
    if (oFRAME_CNT !== '0 || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL wrap_cnt: cnt=%0d busy=%b expected 0,0", oFRAME_CNT, oBUSY);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_mode();
    test_stop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
